// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - Shared types and encodings for the multi-cycle controller
package cpu_pkg;
    localparam int INSTR_W = 12;
    localparam int ADDR_W  = 4;
    localparam int RA_W    = 3;
    localparam int RET_W   = 8;

    typedef enum logic [2:0] {
        OP_STORE = 3'd0,
        OP_LOAD  = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_ADDI  = 3'd4,
        OP_BEQ   = 3'd5,
        OP_NOP   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic PC_SEL_JUMP = 1'b0;
    localparam logic PC_SEL_INC  = 1'b1;
    localparam logic WR_SEL_ALU  = 1'b0;
    localparam logic WR_SEL_MEM  = 1'b1;
    localparam logic SRC_REG     = 1'b0;
    localparam logic SRC_IMM     = 1'b1;
    localparam logic ALU_ADD     = 1'b0;
    localparam logic ALU_SUB     = 1'b1;

    typedef struct packed {
        logic              pc_sel;
        logic              reg_wr_sel;
        logic              alu_src_sel;
        logic              alu_op;
        logic              rf_we;
        logic              m_we;
        logic              pc_ld;
        logic [RA_W-1:0]   ra1;
        logic [RA_W-1:0]   ra2;
        logic [RA_W-1:0]   wa;
        logic [RA_W-1:0]   cnst;
        logic [ADDR_W-1:0] m_addr;
        logic              is_load;
        logic              is_halt;
    } ctrl_t;
endpackage

// File: rtl/controller_fsm_if.sv
// rtl/controller_fsm_if.sv - Controller to datapath / instruction memory signal bundle
interface controller_fsm_if;
    import cpu_pkg::*;

    logic               go;
    logic [INSTR_W-1:0] instr;
    logic               EQ;
    logic               PC_sel;
    logic               pc_ld;
    logic               reg_wr_sel;
    logic               ALU_src_sel;
    logic               RF_we;
    logic               ALU_op;
    logic [RA_W-1:0]    ra1;
    logic [RA_W-1:0]    ra2;
    logic [RA_W-1:0]    wa;
    logic [RA_W-1:0]    constant;
    logic               M_we;
    logic [ADDR_W-1:0]  M_addr;
    logic               busy;
    logic               halted;
    logic [RET_W-1:0]   retired;

    modport master (
        input  go, instr, EQ,
        output PC_sel, pc_ld, reg_wr_sel, ALU_src_sel, RF_we, ALU_op,
               ra1, ra2, wa, constant, M_we, M_addr, busy, halted, retired
    );

    modport slave (
        output go, instr, EQ,
        input  PC_sel, pc_ld, reg_wr_sel, ALU_src_sel, RF_we, ALU_op,
               ra1, ra2, wa, constant, M_we, M_addr, busy, halted, retired
    );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - Combinational IR decode into a per-opcode control bundle
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    input  logic               i_eq,
    output ctrl_t              o_ctrl
);
    opcode_t           w_op;
    logic [RA_W-1:0]   w_a;
    logic [RA_W-1:0]   w_b;
    logic [RA_W-1:0]   w_c;
    logic [ADDR_W-1:0] w_addr;

    assign w_op   = opcode_t'(i_ir[11:9]);
    assign w_a    = i_ir[8:6];
    assign w_b    = i_ir[5:3];
    assign w_c    = i_ir[2:0];
    assign w_addr = i_ir[3:0];

    // LOAD requests its register write and PC load here; the FSM defers both to WB.
    always_comb begin
        o_ctrl        = '0;
        o_ctrl.pc_sel = PC_SEL_INC;
        case (w_op)
            OP_STORE: begin
                o_ctrl.ra2    = w_a;
                o_ctrl.m_we   = 1'b1;
                o_ctrl.m_addr = w_addr;
                o_ctrl.pc_ld  = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.m_addr     = w_addr;
                o_ctrl.wa         = w_a;
                o_ctrl.reg_wr_sel = WR_SEL_MEM;
                o_ctrl.rf_we      = 1'b1;
                o_ctrl.pc_ld      = 1'b1;
                o_ctrl.is_load    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                o_ctrl.ra1         = w_b;
                o_ctrl.ra2         = w_c;
                o_ctrl.wa          = w_a;
                o_ctrl.reg_wr_sel  = WR_SEL_ALU;
                o_ctrl.alu_src_sel = SRC_REG;
                o_ctrl.alu_op      = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
                o_ctrl.rf_we       = 1'b1;
                o_ctrl.pc_ld       = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.ra1         = w_b;
                o_ctrl.wa          = w_a;
                o_ctrl.alu_src_sel = SRC_IMM;
                o_ctrl.alu_op      = ALU_ADD;
                o_ctrl.cnst        = w_c;
                o_ctrl.rf_we       = 1'b1;
                o_ctrl.pc_ld       = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.ra1         = w_a;
                o_ctrl.ra2         = w_b;
                o_ctrl.alu_src_sel = SRC_REG;
                o_ctrl.alu_op      = ALU_SUB;
                o_ctrl.cnst        = w_c;
                o_ctrl.pc_sel      = i_eq ? PC_SEL_JUMP : PC_SEL_INC;
                o_ctrl.pc_ld       = 1'b1;
            end
            OP_NOP:  o_ctrl.pc_ld   = 1'b1;
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/controller_fsm.sv
// rtl/controller_fsm.sv - Multi-cycle FETCH/EXEC/WB sequencer for the 4-bit datapath
module controller_fsm
    import cpu_pkg::*;
(
    input logic              clk,
    input logic              reset,
    controller_fsm_if.master bus
);
    state_t             r_state;
    state_t             w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [RET_W-1:0]   r_retired;
    logic               w_retire;
    ctrl_t              w_ctrl;

    instr_decoder u_dec (
        .i_ir   (r_ir),
        .i_eq   (bus.EQ),
        .o_ctrl (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.go) w_next = S_FETCH;
            S_FETCH:  w_next = S_EXEC;
            S_EXEC: begin
                if (w_ctrl.is_load)      w_next = S_WB;
                else if (w_ctrl.is_halt) w_next = S_HALTED;
                else                     w_next = S_FETCH;
            end
            S_WB:     w_next = S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PC_sel      = PC_SEL_INC;
        bus.pc_ld       = 1'b0;
        bus.reg_wr_sel  = 1'b0;
        bus.ALU_src_sel = 1'b0;
        bus.RF_we       = 1'b0;
        bus.ALU_op      = 1'b0;
        bus.ra1         = '0;
        bus.ra2         = '0;
        bus.wa          = '0;
        bus.constant    = '0;
        bus.M_we        = 1'b0;
        bus.M_addr      = '0;
        bus.busy        = 1'b0;
        bus.halted      = 1'b0;
        bus.retired     = '0;
        if (reset) begin
            bus.retired = r_retired;
            case (r_state)
                S_FETCH: bus.busy = 1'b1;
                S_EXEC, S_WB: begin
                    bus.busy        = 1'b1;
                    bus.PC_sel      = w_ctrl.pc_sel;
                    bus.reg_wr_sel  = w_ctrl.reg_wr_sel;
                    bus.ALU_src_sel = w_ctrl.alu_src_sel;
                    bus.ALU_op      = w_ctrl.alu_op;
                    bus.ra1         = w_ctrl.ra1;
                    bus.ra2         = w_ctrl.ra2;
                    bus.wa          = w_ctrl.wa;
                    bus.constant    = w_ctrl.cnst;
                    bus.M_addr      = w_ctrl.m_addr;
                    bus.M_we        = w_ctrl.m_we;
                    bus.RF_we       = w_ctrl.rf_we & ~w_ctrl.is_load;
                    bus.pc_ld       = w_ctrl.pc_ld & ~w_ctrl.is_load;
                    if (r_state == S_WB) begin
                        bus.RF_we  = 1'b1;
                        bus.pc_ld  = 1'b1;
                        bus.PC_sel = PC_SEL_INC;
                    end
                end
                S_HALTED: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)                  r_ir <= '0;
        else if (r_state == S_FETCH) r_ir <= bus.instr;
    end

    // Every EXEC except LOAD's retires (HALT retires as it enters HALTED); LOAD retires in WB.
    assign w_retire = ((r_state == S_EXEC) && !w_ctrl.is_load) || (r_state == S_WB);

    always_ff @(posedge clk) begin
        if (!reset)        r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + RET_W'(1);
    end
endmodule

// File: tb/tb_controller_fsm.sv
// tb/tb_controller_fsm.sv - Randomized scoreboard bench for controller_fsm
module tb_controller_fsm;
    import cpu_pkg::*;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_ld;
        logic       reg_wr_sel;
        logic       alu_src_sel;
        logic       rf_we;
        logic       alu_op;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [2:0] wa;
        logic [2:0] cnst;
        logic       m_we;
        logic [3:0] m_addr;
        logic       busy;
        logic       halted;
        logic [7:0] retired;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        go;
        logic        eq;
        logic [11:0] instr;
        outs_t       exp;
        string       tag;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;

    controller_fsm_if bus();

    controller_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cyc_t       stim_q[$];
    cyc_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_retired = 8'd0;

    function automatic outs_t quiet(input logic busy);
        outs_t o;
        o         = '0;
        o.pc_sel  = 1'b1;
        o.busy    = busy;
        o.retired = m_retired;
        return o;
    endfunction

    // Expected EXEC-cycle outputs straight from the instruction table.
    function automatic outs_t exec_out(input logic [11:0] ins, input logic eq);
        outs_t      o;
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        op = ins[11:9];
        a  = ins[8:6];
        b  = ins[5:3];
        c  = ins[2:0];
        o  = quiet(1'b1);
        case (op)
            3'd0: begin o.ra2 = a; o.m_we = 1'b1; o.m_addr = ins[3:0]; o.pc_ld = 1'b1; end
            3'd1: begin o.m_addr = ins[3:0]; o.wa = a; o.reg_wr_sel = 1'b1; end
            3'd2, 3'd3: begin
                o.ra1 = b; o.ra2 = c; o.wa = a; o.rf_we = 1'b1; o.pc_ld = 1'b1;
                o.alu_op = (op == 3'd3);
            end
            3'd4: begin
                o.ra1 = b; o.wa = a; o.alu_src_sel = 1'b1; o.cnst = c;
                o.rf_we = 1'b1; o.pc_ld = 1'b1;
            end
            3'd5: begin
                o.ra1 = a; o.ra2 = b; o.alu_op = 1'b1; o.cnst = c;
                o.pc_sel = ~eq; o.pc_ld = 1'b1;
            end
            3'd6: o.pc_ld = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input logic rst, input logic go, input logic eq,
                        input logic [11:0] ins, input outs_t e, input string tag);
        cyc_t c;
        c.rst = rst; c.go = go; c.eq = eq; c.instr = ins; c.exp = e; c.tag = tag;
        stim_q.push_back(c);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            m_retired = 8'd0;
            push(1'b0, 1'($urandom), 1'($urandom), 12'($urandom), quiet(1'b0), "reset");
        end
    endtask

    task automatic do_idle(input logic go);
        push(1'b1, go, 1'($urandom), 12'($urandom), quiet(1'b0), "idle");
    endtask

    task automatic do_fetch(input logic [11:0] ins, input string tag);
        push(1'b1, 1'($urandom), 1'($urandom), ins, quiet(1'b1), {tag, "_fetch"});
    endtask

    task automatic do_instr(input logic [11:0] ins, input logic eq, input string tag);
        outs_t e;
        do_fetch(ins, tag);
        e = exec_out(ins, eq);
        push(1'b1, 1'($urandom), eq, 12'($urandom), e, {tag, "_exec"});
        if (ins[11:9] == 3'd1) begin
            e.rf_we = 1'b1;
            e.pc_ld = 1'b1;
            push(1'b1, 1'($urandom), 1'($urandom), 12'($urandom), e, {tag, "_wb"});
        end
        m_retired = m_retired + 8'd1;
    endtask

    function automatic logic [11:0] rand_instr();
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        return {op, 9'($urandom)};
    endfunction

    task automatic build();
        do_reset(2);
        do_idle(1'b0);
        do_idle(1'b1);
        for (int i = 0; i < 5; i++) do_instr(rand_instr(), 1'($urandom), "warm");
        do_fetch(12'b000_101_00_0110, "store_abort");
        do_reset(2);
        do_idle(1'b0);
        do_idle(1'b1);
        do_instr(12'b100_001_000_011, 1'b0, "addi");
        do_instr(12'b010_010_001_001, 1'b0, "add");
        do_instr(12'b001_011_00_1001, 1'b0, "load");
        do_instr(12'b101_001_010_101, 1'b1, "beq_taken");
        do_instr(12'b101_001_010_101, 1'b0, "beq_not");
        for (int i = 0; i < 200; i++) do_instr(rand_instr(), 1'($urandom), "rand");
        for (int i = 0; i < 256; i++) do_instr({3'b110, 9'($urandom)}, 1'($urandom), "nop");
        do_instr(12'b111_000_000_000, 1'($urandom), "halt");
        for (int i = 0; i < 4; i++) begin
            outs_t e;
            e        = quiet(1'b0);
            e.halted = 1'b1;
            push(1'b1, 1'(i % 2 == 0), 1'($urandom), 12'($urandom), e, "halted");
        end
        do_reset(1);
        do_idle(1'b0);
    endtask

    initial begin
        cyc_t c;
        reset     = 1'b0;
        bus.go    = 1'b0;
        bus.instr = '0;
        bus.EQ    = 1'b0;
        build();
        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            c         = stim_q.pop_front();
            reset     = c.rst;
            bus.go    = c.go;
            bus.EQ    = c.eq;
            bus.instr = c.instr;
            exp_q.push_back(c);
        end
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    always @(negedge clk) begin
        cyc_t  e;
        outs_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.PC_sel, bus.pc_ld, bus.reg_wr_sel, bus.ALU_src_sel, bus.RF_we,
                   bus.ALU_op, bus.ra1, bus.ra2, bus.wa, bus.constant, bus.M_we,
                   bus.M_addr, bus.busy, bus.halted, bus.retired};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got=%h required=%h (retired got=%0d required=%0d)",
                         e.tag, got, e.exp, got.retired, e.exp.retired);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, pending=%0d", stim_q.size());
        $fatal(1);
    end
endmodule
